// File: rtl/fft_frame_loader_if.sv
// Sample-in / frame-out bundle between the audio source, the frame loader and the FFT.
// The loader side uses the slave modport.
interface fft_frame_loader_if #(
  parameter int SAMPLE_W = 18
);
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       fft_done;
  logic                       fft_start;
  logic [35:0]                frame [0:15];
  logic                       busy;
  logic                       overrun;
  logic [7:0]                 drop_cnt;

  modport master (
    output sample_valid, sample_in, fft_done,
    input  fft_start, frame, busy, overrun, drop_cnt
  );

  modport slave (
    input  sample_valid, sample_in, fft_done,
    output fft_start, frame, busy, overrun, drop_cnt
  );
endinterface

// File: rtl/fft_frame_loader.sv
// Slides a 16-sample window over the sample stream and hands {re,im} frames to the FFT; fft_start
// pulses 2 cycles after the completing sample. Samples are never stalled: excess input while busy is counted as overrun.
module fft_frame_loader #(
  parameter int SAMPLE_W = 18,
  parameter int HOP      = 16,
  parameter int SHIFT    = 4
) (
  input logic               clk,
  input logic               reset_n,
  fft_frame_loader_if.slave bus
);
  typedef enum logic [1:0] {FILL, ARMED, BUSY} state_t;

  localparam int         LSH   = 18 - SAMPLE_W;
  localparam logic [4:0] HOP_N = 5'(HOP);

  state_t            state;
  logic [35:0]       win [0:15];
  logic [3:0]        wr_ptr;
  logic [4:0]        fill_cnt;
  logic [4:0]        hop_cnt;
  logic              done_q;
  logic signed [17:0] x_al;
  logic signed [17:0] re;
  logic              hop_full;
  logic              launch;

  // Left-align the sample, then pre-scale to leave headroom for FFT growth.
  assign x_al     = $signed(18'(bus.sample_in)) <<< LSH;
  assign re       = x_al >>> SHIFT;
  assign hop_full = (hop_cnt >= HOP_N);
  assign launch   = hop_full && ((state == ARMED) || (state == FILL && fill_cnt == 5'd16));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= FILL;
      wr_ptr        <= '0;
      fill_cnt      <= '0;
      hop_cnt       <= '0;
      done_q        <= 1'b0;
      bus.fft_start <= 1'b0;
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.drop_cnt  <= '0;
      for (int k = 0; k < 16; k++) begin
        win[k]       <= '0;
        bus.frame[k] <= '0;
      end
    end else begin
      bus.fft_start <= 1'b0;
      done_q        <= bus.fft_done;

      if (bus.sample_valid) begin
        win[wr_ptr] <= {re, 18'b0};
        wr_ptr      <= wr_ptr + 4'd1;
        if (fill_cnt != 5'd16) fill_cnt <= fill_cnt + 5'd1;
      end

      // A sample arriving in the launch cycle belongs to the next hop, not this frame.
      if (launch)
        hop_cnt <= {4'b0, bus.sample_valid};
      else if (bus.sample_valid && hop_cnt != HOP_N)
        hop_cnt <= hop_cnt + 5'd1;

      if (launch) begin
        for (int k = 0; k < 16; k++)
          bus.frame[k] <= win[wr_ptr + 4'(k)];
        bus.fft_start <= 1'b1;
        bus.busy      <= 1'b1;
        state         <= BUSY;
      end else begin
        case (state)
          FILL:  if (fill_cnt == 5'd16) state <= ARMED;
          ARMED: ;
          BUSY: begin
            if (bus.fft_done && !done_q) begin
              state    <= ARMED;
              bus.busy <= 1'b0;
            end
            if (bus.sample_valid && hop_cnt == HOP_N) begin
              bus.overrun <= 1'b1;
              if (bus.drop_cnt != 8'hFF) bus.drop_cnt <= bus.drop_cnt + 8'd1;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end
endmodule
